// File: rtl/gpio_irq_pkg.sv
// Shared register map and helpers for the gpio input/interrupt block.
// The gpio port block decodes the same address space, so both agree on these values.
package gpio_irq_pkg;

  typedef enum logic [1:0] {
    REG_LEVEL   = 2'b00,
    REG_RISE_EN = 2'b01,
    REG_FALL_EN = 2'b10,
    REG_PENDING = 2'b11
  } reg_addr_e;

  // gpio output-side registers sharing the address space
  localparam logic [1:0] ADDR_OUT = 2'b00;
  localparam logic [1:0] ADDR_DIR = 2'b01;

  function automatic int cnt_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/gpio_irq_if.sv
// Register bus between the CPU-side decode and the gpio_irq block.
interface gpio_irq_if #(
  parameter int npins = 16
);
  logic [npins-1:0] data_write;
  logic [1:0]       addr;
  logic             w_strobe;
  logic [npins-1:0] data_read;

  modport master (output data_write, addr, w_strobe, input data_read);
  modport slave  (input data_write, addr, w_strobe, output data_read);
endinterface

// File: rtl/gpio_irq_debounce.sv
// One input bit: 2-flop synchroniser, tick-sampled history, debounced level
// and single-cycle rise/fall pulses registered alongside the level change.
module gpio_irq_debounce #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  input  logic tick,
  output logic level,
  output logic rise,
  output logic fall
);
  logic             sync_p0;
  logic             sync_p1;
  logic [DEPTH-1:0] hist;
  logic [DEPTH-1:0] hist_next;

  assign hist_next = {hist[DEPTH-2:0], sync_p1};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      hist    <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      sync_p0 <= pin;
      sync_p1 <= sync_p0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      // Decision uses the history including the sample being shifted in now
      if (tick) begin
        hist <= hist_next;
        if (&hist_next && !level) begin
          level <= 1'b1;
          rise  <= 1'b1;
        end else if (~|hist_next && level) begin
          level <= 1'b0;
          fall  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gpio_irq.sv
// GPIO input interrupt block: per-bit debounce, edge enables, W1C pending
// register and a registered level interrupt, behind the gpio register bus.
module gpio_irq
  import gpio_irq_pkg::*;
#(
  parameter int npins    = 16,
  parameter int PRESCALE = 1000,
  parameter int DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [npins-1:0] pins_in,
  gpio_irq_if.slave        bus,
  output logic             irq
);
  localparam int CNT_W = cnt_width(PRESCALE);

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic [npins-1:0] level;
  logic [npins-1:0] rise;
  logic [npins-1:0] fall;
  logic [npins-1:0] rise_en;
  logic [npins-1:0] fall_en;
  logic [npins-1:0] pending;
  logic [npins-1:0] pend_set;
  logic [npins-1:0] pend_clr;
  logic [npins-1:0] rd_mux;

  assign tick = (tick_cnt == CNT_W'(PRESCALE - 1));

  for (genvar i = 0; i < npins; i++) begin : g_bit
    gpio_irq_debounce #(.DEPTH(DEPTH)) u_debounce (
      .clk   (clk),
      .reset (reset),
      .pin   (pins_in[i]),
      .tick  (tick),
      .level (level[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  always_comb begin
    pend_set = (rise & rise_en) | (fall & fall_en);
    pend_clr = '0;
    if (bus.w_strobe && bus.addr == REG_PENDING) pend_clr = bus.data_write;
    case (reg_addr_e'(bus.addr))
      REG_LEVEL:   rd_mux = level;
      REG_RISE_EN: rd_mux = rise_en;
      REG_FALL_EN: rd_mux = fall_en;
      REG_PENDING: rd_mux = pending;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt      <= '0;
      rise_en       <= '0;
      fall_en       <= '0;
      pending       <= '0;
      irq           <= 1'b0;
      bus.data_read <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (bus.w_strobe && bus.addr == REG_RISE_EN) rise_en <= bus.data_write;
      if (bus.w_strobe && bus.addr == REG_FALL_EN) fall_en <= bus.data_write;
      // New edges take priority over a same-cycle W1C of the same bit
      pending       <= (pending & ~pend_clr) | pend_set;
      irq           <= |pending;
      bus.data_read <= rd_mux;
    end
  end

endmodule

// File: tb/tb_gpio_irq.sv
// Directed bench for gpio_irq: register table, edge latency, glitch rejection,
// W1C priority, mask changes and prescaled debounce with mid-debounce reset.
module tb_gpio_irq;
  localparam int NP = 16;

  logic          clk = 1'b0;
  logic          reset_a;
  logic          reset_b;
  logic [NP-1:0] pins_a;
  logic [NP-1:0] pins_b;
  logic          irq_a;
  logic          irq_b;

  always #5 clk = ~clk;

  gpio_irq_if #(.npins(NP)) bus_a ();
  gpio_irq_if #(.npins(NP)) bus_b ();

  gpio_irq #(.npins(NP), .PRESCALE(1), .DEPTH(4)) dut_a (
    .clk(clk), .reset(reset_a), .pins_in(pins_a), .bus(bus_a), .irq(irq_a)
  );

  gpio_irq #(.npins(NP), .PRESCALE(4), .DEPTH(4)) dut_b (
    .clk(clk), .reset(reset_b), .pins_in(pins_b), .bus(bus_b), .irq(irq_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr_a(input logic [1:0] a, input logic [15:0] d);
    bus_a.addr       = a;
    bus_a.data_write = d;
    bus_a.w_strobe   = 1'b1;
    step();
    bus_a.w_strobe   = 1'b0;
  endtask

  task automatic rd_a(input logic [1:0] a, output logic [15:0] d);
    bus_a.addr = a;
    step();
    d = bus_a.data_read;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] rd;
    int first_lvl;
    int first_irq;

    vecs[0]  = '{1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 2'd1, 16'h0000, 16'h0000, 1'b0};
    vecs[2]  = '{1'b0, 2'd2, 16'h0000, 16'h0000, 1'b0};
    vecs[3]  = '{1'b0, 2'd3, 16'h0000, 16'h0000, 1'b0};
    vecs[4]  = '{1'b1, 2'd0, 16'hffff, 16'h0000, 1'b0};
    vecs[5]  = '{1'b1, 2'd1, 16'h00a5, 16'h00a5, 1'b0};
    vecs[6]  = '{1'b1, 2'd2, 16'h5a00, 16'h5a00, 1'b0};
    vecs[7]  = '{1'b1, 2'd3, 16'hffff, 16'h0000, 1'b0};
    vecs[8]  = '{1'b0, 2'd1, 16'h0000, 16'h00a5, 1'b0};
    vecs[9]  = '{1'b1, 2'd1, 16'hffff, 16'hffff, 1'b0};
    vecs[10] = '{1'b1, 2'd1, 16'h0000, 16'h0000, 1'b0};
    vecs[11] = '{1'b1, 2'd2, 16'h0000, 16'h0000, 1'b0};

    reset_a = 1'b1;
    reset_b = 1'b1;
    pins_a  = '0;
    pins_b  = '0;
    bus_a.addr = 2'd0; bus_a.data_write = '0; bus_a.w_strobe = 1'b0;
    bus_b.addr = 2'd0; bus_b.data_write = '0; bus_b.w_strobe = 1'b0;
    idle(3);
    check("reset_read_a", bus_a.data_read, 16'h0000);
    check("reset_irq_a", irq_a, 1'b0);
    reset_a = 1'b0;

    // Register access table, pins static so nothing pends
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) wr_a(vecs[i].addr, vecs[i].wdata);
      rd_a(vecs[i].addr, rd);
      check($sformatf("vec%0d_read", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), irq_a, vecs[i].exp_irq);
    end

    // Rising edge on bit 0: level after 2 sync + 4 ticks, read one clk later, irq two
    wr_a(2'd1, 16'h0001);
    bus_a.addr = 2'd0;
    pins_a[0] = 1'b1;
    first_lvl = 0;
    first_irq = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (first_lvl == 0 && bus_a.data_read[0]) first_lvl = k;
      if (first_irq == 0 && irq_a) first_irq = k;
    end
    check("rise_level_cycle", first_lvl, 7);
    check("rise_irq_cycle", first_irq, 8);
    rd_a(2'd3, rd);
    check("rise_pending", rd, 16'h0001);

    // Three-clock glitch on bit 1 is rejected
    wr_a(2'd1, 16'h0003);
    pins_a[1] = 1'b1;
    idle(3);
    pins_a[1] = 1'b0;
    idle(12);
    rd_a(2'd0, rd);
    check("glitch_level", rd, 16'h0001);
    rd_a(2'd3, rd);
    check("glitch_pending", rd, 16'h0001);

    // Falling edge on bit 15 with only fall_en[15]
    pins_a[15] = 1'b1;
    idle(10);
    rd_a(2'd0, rd);
    check("b15_high_level", rd, 16'h8001);
    wr_a(2'd3, 16'h0001);
    rd_a(2'd3, rd);
    check("clear_b0_pending", rd, 16'h0000);
    wr_a(2'd1, 16'h0000);
    wr_a(2'd2, 16'h8000);
    pins_a[15] = 1'b0;
    idle(10);
    rd_a(2'd3, rd);
    check("fall_pending", rd, 16'h8000);
    check("fall_irq", irq_a, 1'b1);
    rd_a(2'd0, rd);
    check("fall_level", rd, 16'h0001);
    wr_a(2'd3, 16'h0000);
    rd_a(2'd3, rd);
    check("w1c_zero_noop", rd, 16'h8000);
    wr_a(2'd3, 16'h8000);
    check("irq_after_w1c_edge", irq_a, 1'b1);
    step();
    check("irq_dropped", irq_a, 1'b0);
    rd_a(2'd3, rd);
    check("w1c_cleared", rd, 16'h0000);

    // Same-cycle W1C and new rise on bit 0: set wins
    pins_a[0] = 1'b0;
    idle(10);
    wr_a(2'd1, 16'h0001);
    pins_a[0] = 1'b1;
    idle(6);
    wr_a(2'd3, 16'h0001);
    rd_a(2'd3, rd);
    check("set_beats_clear", rd, 16'h0001);
    wr_a(2'd3, 16'h0001);
    rd_a(2'd3, rd);
    check("bit0_cleared", rd, 16'h0000);

    // Clearing masks leaves pending[3] and irq standing
    wr_a(2'd1, 16'h0008);
    pins_a[3] = 1'b1;
    idle(10);
    rd_a(2'd3, rd);
    check("b3_pending", rd, 16'h0008);
    wr_a(2'd1, 16'h0000);
    wr_a(2'd2, 16'h0000);
    idle(2);
    rd_a(2'd3, rd);
    check("mask_clear_keeps_pending", rd, 16'h0008);
    check("mask_clear_keeps_irq", irq_a, 1'b1);
    wr_a(2'd3, 16'h0008);
    step();
    check("b3_irq_dropped", irq_a, 1'b0);

    // Prescaled instance: reset aligns tick phase, ticks at 4,8,12,16 clk after reset
    reset_b = 1'b0;
    pins_b[2] = 1'b1;
    bus_b.addr = 2'd1;
    bus_b.data_write = 16'h0004;
    bus_b.w_strobe = 1'b1;
    first_lvl = 0;
    first_irq = 0;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (k == 1) begin
        bus_b.w_strobe = 1'b0;
        bus_b.addr = 2'd0;
      end
      if (k >= 2 && first_lvl == 0 && bus_b.data_read[2]) first_lvl = k;
      if (first_irq == 0 && irq_b) first_irq = k;
    end
    check("ps4_level_cycle", first_lvl, 17);
    check("ps4_irq_cycle", first_irq, 18);
    bus_b.addr = 2'd3;
    step();
    check("ps4_pending", bus_b.data_read, 16'h0004);

    // Reset after two ticks discards the partial history
    reset_b = 1'b1;
    pins_b[2] = 1'b0;
    bus_b.addr = 2'd0;
    idle(3);
    reset_b = 1'b0;
    pins_b[2] = 1'b1;
    idle(8);
    reset_b = 1'b1;
    step();
    check("ps4_reset_read", bus_b.data_read, 16'h0000);
    check("ps4_reset_irq", irq_b, 1'b0);
    reset_b = 1'b0;
    bus_b.addr = 2'd1;
    bus_b.data_write = 16'h0004;
    bus_b.w_strobe = 1'b1;
    first_lvl = 0;
    first_irq = 0;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (k == 1) begin
        bus_b.w_strobe = 1'b0;
        bus_b.addr = 2'd3;
      end
      if (k == 2) begin
        check("ps4_pending_after_reset", bus_b.data_read, 16'h0000);
        bus_b.addr = 2'd0;
      end
      if (k >= 3 && first_lvl == 0 && bus_b.data_read[2]) first_lvl = k;
      if (first_irq == 0 && irq_b) first_irq = k;
    end
    check("ps4_rerun_level_cycle", first_lvl, 17);
    check("ps4_rerun_irq_cycle", first_irq, 18);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
